// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM state and bus access size encoding.
package load_store_unit_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_t;

  function automatic int size_bytes(input mem_size_t s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Load data extraction: picks the addressed bytes out of a two-beat window
// and sign- or zero-extends them to the bus width.
module load_aligner
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           beat0_i,
  input  logic [DATA_W-1:0]           beat1_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  mem_size_t                   size_i,
  input  logic                        unsigned_i,
  output logic [DATA_W-1:0]           rdata_o
);

  logic [2*DATA_W-1:0] shifted;
  logic                sgn;
  int                  nbits;

  always_comb begin
    shifted = {beat1_i, beat0_i} >> {off_i, 3'b000};
    nbits   = 8 * size_bytes(size_i);
    if (nbits > DATA_W) nbits = DATA_W;
    case (size_i)
      SZ_BYTE: sgn = shifted[7];
      SZ_HALF: sgn = shifted[15];
      SZ_WORD: sgn = shifted[31];
      default: sgn = shifted[63];
    endcase
    rdata_o = '0;
    for (int i = 0; i < DATA_W; i++)
      rdata_o[i] = (i < nbits) ? shifted[i] : (!unsigned_i && sgn);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one pipeline request becomes one or two bus beats, with
// lane positioning, byte enables, load extension and a per-phase timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT_CYC      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_ben_n,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  function automatic logic two_beats(input logic [OFF_W-1:0] off, input mem_size_t sz);
    return (int'(off) + size_bytes(sz)) > LANES;
  endfunction

  function automatic logic req_err(input logic [OFF_W-1:0] off, input mem_size_t sz);
    return (two_beats(off, sz) && !ALLOW_MISALIGNED) || (sz == SZ_DWORD && DATA_W == 32);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic b);
    return {a[31:OFF_W], {OFF_W{1'b0}}} + (b ? 32'(LANES) : 32'd0);
  endfunction

  // Enable mask over the two-beat byte window; beat selects which half.
  function automatic logic [LANES-1:0] beat_ben_n(input logic [OFF_W-1:0] off,
                                                  input mem_size_t sz, input logic b);
    logic [2*LANES-1:0] m;
    int o, nb;
    o  = int'(off);
    nb = size_bytes(sz);
    m  = '0;
    for (int i = 0; i < 2*LANES; i++) m[i] = (i >= o) && (i < o + nb);
    return b ? ~m[2*LANES-1:LANES] : ~m[LANES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] beat_wdata(input logic [OFF_W-1:0] off,
                                                   input logic [DATA_W-1:0] wd, input logic b);
    logic [2*DATA_W-1:0] w;
    w = {{DATA_W{1'b0}}, wd} << {off, 3'b000};
    return b ? w[2*DATA_W-1:DATA_W] : w[DATA_W-1:0];
  endfunction

  lsu_state_t          state_q;
  logic [31:0]         addr_q;
  mem_size_t           size_q;
  logic                uns_q, write_q, beat_q;
  logic [DATA_W-1:0]   wdata_q, beat0_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                mem_req_q, mem_we_q;
  logic [LANES-1:0]    mem_ben_n_q;
  logic [31:0]         mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                resp_valid_q, resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;

  logic [OFF_W-1:0]    off;
  logic                last_beat, tmo_hit;
  logic [DATA_W-1:0]   load_d;

  assign off       = addr_q[OFF_W-1:0];
  assign last_beat = beat_q | ~two_beats(off, size_q);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // On the final read beat, beat 0 comes from the bus directly for single-beat loads.
  load_aligner #(.DATA_W(DATA_W)) u_align (
    .beat0_i   (beat_q ? beat0_q : mem_rdata),
    .beat1_i   (mem_rdata),
    .off_i     (off),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .rdata_o   (load_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      beat_q       <= 1'b0;
      wdata_q      <= '0;
      beat0_q      <= '0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_ben_n_q  <= '1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= mem_size_t'(req_size);
          uns_q   <= req_unsigned;
          write_q <= req_write;
          wdata_q <= req_wdata;
          beat_q  <= 1'b0;
          tmo_q   <= '0;
          if (req_err(req_addr[OFF_W-1:0], mem_size_t'(req_size))) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_write;
            mem_addr_q  <= beat_addr(req_addr, 1'b0);
            mem_ben_n_q <= beat_ben_n(req_addr[OFF_W-1:0], mem_size_t'(req_size), 1'b0);
            mem_wdata_q <= beat_wdata(req_addr[OFF_W-1:0], req_wdata, 1'b0);
          end
        end
        ISSUE: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          tmo_q     <= '0;
          if (!write_q) begin
            state_q <= WAIT;
          end else if (last_beat) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            beat_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= beat_addr(addr_q, 1'b1);
            mem_ben_n_q <= beat_ben_n(off, size_q, 1'b1);
            mem_wdata_q <= beat_wdata(off, wdata_q, 1'b1);
          end
        end else if (tmo_hit) begin
          mem_req_q    <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
        WAIT: if (mem_rvalid) begin
          tmo_q <= '0;
          if (last_beat) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_d;
          end else begin
            beat0_q     <= mem_rdata;
            beat_q      <= 1'b1;
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= beat_addr(addr_q, 1'b1);
            mem_ben_n_q <= beat_ben_n(off, size_q, 1'b1);
          end
        end else if (tmo_hit) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_ben_n  = mem_ben_n_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against a byte-level reference model of the bus and load extension.
module tb_load_store_unit;

  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req_valid, req_valid1, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic          req_ready, resp_valid, resp_err, busy, mem_req, mem_we;
  logic [DW-1:0] resp_rdata, mem_wdata;
  logic [3:0]    mem_ben_n;
  logic [31:0]   mem_addr;

  logic          req_ready1, resp_valid1, resp_err1, busy1, mem_req1, mem_we1;
  logic [DW-1:0] resp_rdata1, mem_wdata1;
  logic [3:0]    mem_ben_n1;
  logic [31:0]   mem_addr1;

  load_store_unit #(.DATA_W(DW), .ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYC(TMO)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_ben_n(mem_ben_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  load_store_unit #(.DATA_W(DW), .ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYC(TMO)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .busy(busy1), .mem_req(mem_req1),
    .mem_gnt(mem_gnt), .mem_we(mem_we1), .mem_ben_n(mem_ben_n1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  int vectors = 0, miscompares = 0;

  logic [31:0] ob_addr[2], ob_wd[2], ob_rdata;
  logic [3:0]  ob_ben[2];
  int          ob_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One access with an always-granting bus that returns read data the cycle after grant.
  task automatic run_acc(input bit w, input bit [1:0] sz, input bit uns, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rd0, input bit [31:0] rd1);
    int off, nb, nbeats, explat, beat, lat, gi;
    bit pend, err;
    logic [31:0] pdata, ev, ewd, wmask, tmp;
    logic [3:0]  eben;
    off = int'(addr % 4); nb = 1 << sz;
    nbeats = (off + nb > 4) ? 2 : 1;
    err = (sz == 2'd3);
    explat = err ? 1 : (w ? 1 + nbeats : 1 + 2*nbeats);
    ev = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        gi = off + i;
        ev[8*i +: 8] = (gi < 4) ? rd0[8*gi +: 8] : rd1[8*(gi-4) +: 8];
      end
      if (!uns && nb < 4 && ev[8*nb-1]) ev = ev | (32'hFFFF_FFFF << (8*nb));
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    chk("ready_at_accept", {63'd0, req_ready}, 64'd1);
    beat = 0; pend = 1'b0; lat = 0; pdata = '0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_rvalid = pend;
      mem_rdata = pend ? pdata : $urandom;
      pend = 1'b0;
      if (mem_req) begin
        eben = '1; ewd = '0; wmask = '0;
        for (int l = 0; l < 4; l++) begin
          gi = 4*beat + l;
          if (gi >= off && gi < off + nb) begin
            eben[l] = 1'b0;
            wmask[8*l +: 8] = 8'hFF;
            tmp = wd >> (8*(gi - off));
            ewd[8*l +: 8] = tmp[7:0];
          end
        end
        chk("beat_addr", mem_addr, (addr & ~32'd3) + 32'(4*beat));
        chk("beat_ben_n", mem_ben_n, eben);
        chk("beat_we", mem_we, w);
        if (w) chk("beat_wdata", mem_wdata & wmask, ewd);
        if (beat < 2) begin
          ob_addr[beat] = mem_addr; ob_ben[beat] = mem_ben_n; ob_wd[beat] = mem_wdata;
        end
        if (!w) begin
          pend = 1'b1;
          pdata = (beat == 0) ? rd0 : rd1;
        end
        beat++;
      end
      if (resp_valid) begin
        lat = k;
        ob_rdata = resp_rdata;
        chk("resp_err", resp_err, err);
        if (err || !w) chk("resp_rdata", resp_rdata, ev);
      end
    end
    ob_lat = lat;
    chk("latency", lat, explat);
    chk("beat_count", beat, err ? 0 : nbeats);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("resp_one_cycle", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    int reqc, lat;
    bit [1:0] sz;
    rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_size = '0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_ben_n", mem_ben_n, 4'hF);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_acc(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0);
    chk("lw_lat", ob_lat, 3);
    chk("lw_rdata", ob_rdata, 32'hDEADBEEF);
    chk("lw_ben", ob_ben[0], 4'b0000);

    run_acc(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0);
    chk("lb_rdata", ob_rdata, 32'hFFFFFF80);
    chk("lb_ben", ob_ben[0], 4'b0111);
    run_acc(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0);
    chk("lbu_rdata", ob_rdata, 32'h00000080);

    run_acc(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h22221111, 32'h44443333);
    chk("lw_mis_addr0", ob_addr[0], 32'h100);
    chk("lw_mis_ben0", ob_ben[0], 4'b0011);
    chk("lw_mis_addr1", ob_addr[1], 32'h104);
    chk("lw_mis_ben1", ob_ben[1], 4'b1100);
    chk("lw_mis_rdata", ob_rdata, 32'h33332222);
    chk("lw_mis_lat", ob_lat, 5);

    run_acc(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000ABCD, 32'h0, 32'h0);
    chk("sh_addr0", ob_addr[0], 32'h100);
    chk("sh_ben0", ob_ben[0], 4'b0111);
    chk("sh_byte3", ob_wd[0] >> 24, 32'hCD);
    chk("sh_addr1", ob_addr[1], 32'h104);
    chk("sh_ben1", ob_ben[1], 4'b1110);
    chk("sh_byte0", ob_wd[1] & 32'hFF, 32'hAB);
    chk("sh_lat", ob_lat, 3);

    run_acc(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 32'h0, 32'h0);

    // Grant never arrives: request must be held for exactly TMO cycles.
    mem_gnt = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h200;
    reqc = 0; lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_req) begin
        reqc++;
        chk("tmo_addr_stable", mem_addr, 32'h200);
      end
      if (resp_valid) begin
        lat = k;
        chk("tmo_err", resp_err, 1'b1);
        chk("tmo_req_dropped", mem_req, 1'b0);
      end
    end
    chk("tmo_req_cycles", reqc, TMO);
    chk("tmo_lat", lat, TMO + 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;

    req_valid1 = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h102;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      chk("nomis_no_req", mem_req1, 1'b0);
      chk("nomis_valid", resp_valid1, k == 1);
      if (k == 1) begin
        chk("nomis_err", resp_err1, 1'b1);
        chk("nomis_rdata", resp_rdata1, 32'd0);
      end
    end

    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", busy, 1'b1);
    chk("wait_no_req", mem_req, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_ben", mem_ben_n, 4'hF);
    chk("midrst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("late_rvalid_ignored", resp_valid, 1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 2'd3;
      run_acc(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              32'h1000 + $urandom_range(0, 63), $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
